// File: rtl/muldiv_unit_pkg.sv
// Shared CPU constants for the iterative multiply/divide unit:
// op encodings, FSM state encodings and the hard-wired zero register.
package muldiv_unit_pkg;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_DIVU = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam logic [3:0] ZERO_REG = 4'd14;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply / divide unit: WIDTH-cycle shift-add multiply and
// restoring radix-2 divide sharing one accumulator, shift register and counter.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [3:0]       rd,
  input  logic [WIDTH-1:0] rs1_val,
  input  logic [WIDTH-1:0] rs2_val,
  output logic             busy,
  output logic             wb_write,
  output logic [3:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data,
  output logic [1:0]       dbg_state
);

  // Handshake: start is taken only when busy is low (IDLE); a taken request
  // yields exactly one wb_write pulse unless rd is the zero register.
  localparam int CW = $clog2(WIDTH);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [1:0]       r_op;
  logic [3:0]       r_rd;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_opb;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;
  logic             r_wb_write;
  logic [3:0]       r_wb_rd;
  logic [WIDTH-1:0] r_wb_data;

  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_sub;
  logic             w_fit;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] w_result;

  assign w_signed = (op == OP_DIV) || (op == OP_REM);
  assign w_a_neg  = w_signed & rs1_val[WIDTH-1];
  assign w_b_neg  = w_signed & rs2_val[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -rs1_val : rs1_val;
  assign w_b_mag  = w_b_neg ? -rs2_val : rs2_val;

  // Partial remainder shifted left by one, pulling in the next dividend bit.
  assign w_rem_sh = {r_acc, r_shift[WIDTH-1]};
  assign w_fit    = (w_rem_sh >= {1'b0, r_opb});
  assign w_sub    = w_rem_sh[WIDTH-1:0] - r_opb;

  always_comb begin
    w_acc_nxt   = '0;
    w_shift_nxt = '0;
    if (r_op == OP_MUL) begin
      // MSB-first multiplier scan: acc = 2*acc + (bit ? multiplicand : 0).
      w_acc_nxt   = {r_acc[WIDTH-2:0], 1'b0} + (r_shift[WIDTH-1] ? r_opb : '0);
      w_shift_nxt = {r_shift[WIDTH-2:0], 1'b0};
    end else begin
      w_acc_nxt   = w_fit ? w_sub : w_rem_sh[WIDTH-1:0];
      w_shift_nxt = {r_shift[WIDTH-2:0], w_fit};
    end
  end

  always_comb begin
    w_result = '0;
    case (r_op)
      OP_MUL:  w_result = w_acc_nxt;
      OP_DIV:  w_result = r_div0 ? '1 : (r_neg_q ? -w_shift_nxt : w_shift_nxt);
      OP_REM:  w_result = r_neg_r ? -w_acc_nxt : w_acc_nxt;
      default: w_result = w_shift_nxt;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_op       <= '0;
      r_rd       <= '0;
      r_acc      <= '0;
      r_shift    <= '0;
      r_opb      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_div0     <= 1'b0;
      r_wb_write <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
    end else begin
      r_wb_write <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_rd    <= rd;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_div0  <= (rs2_val == '0);
            r_shift <= (op == OP_MUL) ? rs2_val : w_a_mag;
            r_opb   <= (op == OP_MUL) ? rs1_val : w_b_mag;
            r_state <= ST_CALC;
          end
        end
        ST_CALC: begin
          r_acc   <= w_acc_nxt;
          r_shift <= w_shift_nxt;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_wb_rd   <= r_rd;
            r_wb_data <= w_result;
            r_state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_wb_write <= (r_rd != ZERO_REG);
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign wb_write  = r_wb_write;
  assign wb_rd     = r_wb_rd;
  assign wb_data   = r_wb_data;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: drivers push expected writes, a negedge
// monitor pops and checks rd, data and latency of every wb_write pulse.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [3:0]   rd;
  logic [W-1:0] rs1_val;
  logic [W-1:0] rs2_val;
  logic         busy;
  logic         wb_write;
  logic [3:0]   wb_rd;
  logic [W-1:0] wb_data;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [35:0]  exp_q[$];
  int           cyc_q[$];
  logic [3:0]   last_rd;
  logic [W-1:0] last_data;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rd(rd),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .busy(busy),
    .wb_write(wb_write), .wb_rd(wb_rd), .wb_data(wb_data),
    .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [35:0] e;
    int c;
    if (!rst && wb_write) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got rd=%0d data=%0h want no write", wb_rd, wb_data);
      end else begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        check("wb_rd", 64'(wb_rd), 64'(e[35:32]));
        check("wb_data", 64'(wb_data), 64'(e[31:0]));
        check("latency", 64'(cyc - c), 64'(LAT));
      end
    end
  end

  // Called at a negedge; returns just after the edge that samples start.
  task automatic do_op(input logic [1:0] o, input logic [3:0] r, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] ex, input bit push);
    op = o; rd = r; rs1_val = a; rs2_val = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (push && r != ZERO_REG) begin
      exp_q.push_back({r, ex});
      cyc_q.push_back(cyc);
      last_rd = r;
      last_data = ex;
    end
  endtask

  // Returns at the first negedge with busy low; n = busy negedges seen.
  task automatic wait_idle(output int n);
    bit done = 0;
    n = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (busy) n++;
      else done = 1;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy after 200 cycles want idle");
    end
  endtask

  task automatic run(input logic [1:0] o, input logic [3:0] r, input logic [W-1:0] a,
                     input logic [W-1:0] b, input logic [W-1:0] ex);
    int n;
    do_op(o, r, a, b, ex, 1'b1);
    wait_idle(n);
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; op = '0; rd = '0; rs1_val = '0; rs2_val = '0;
    last_rd = '0; last_data = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_wb_write", 64'(wb_write), 64'(0));
    check("rst_wb_rd", 64'(wb_rd), 64'(0));
    check("rst_wb_data", 64'(wb_data), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);

    do_op(OP_MUL, 4'd2, 32'd7, -32'sd3, 32'hFFFFFFEB, 1'b1);
    wait_idle(n);
    check("mul_busy_cycles", 64'(n), 64'(LAT));
    check("hold_wb_data", 64'(wb_data), 64'hFFFFFFEB);

    run(OP_DIV,  4'd3, -32'sd7, 32'd2, 32'hFFFFFFFD);
    run(OP_REM,  4'd3, -32'sd7, 32'd2, 32'hFFFFFFFF);
    run(OP_DIV,  4'd4, 32'd7, -32'sd2, 32'hFFFFFFFD);
    run(OP_REM,  4'd4, 32'd7, -32'sd2, 32'd1);
    run(OP_DIVU, 4'd1, 32'd100, 32'd0, 32'hFFFFFFFF);
    run(OP_REM,  4'd1, 32'd100, 32'd0, 32'd100);
    run(OP_DIV,  4'd5, -32'sd5, 32'd0, 32'hFFFFFFFF);
    run(OP_REM,  4'd5, -32'sd5, 32'd0, 32'hFFFFFFFB);
    run(OP_DIV,  4'd6, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    run(OP_REM,  4'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0);
    run(OP_DIVU, 4'd7, 32'hFFFFFFFF, 32'd3, 32'h55555555);
    run(OP_MUL,  4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1);
    run(OP_MUL,  4'd9, 32'h00010001, 32'h00010001, 32'h00020001);

    // zero register: normal timing, no write
    do_op(OP_MUL, ZERO_REG, 32'd5, 32'd6, 32'd30, 1'b1);
    wait_idle(n);
    check("zero_reg_busy_cycles", 64'(n), 64'(LAT));

    // start while busy is ignored, then back-to-back starts
    do_op(OP_DIVU, 4'd10, 32'd1000, 32'd10, 32'd100, 1'b1);
    repeat (5) @(negedge clk);
    op = OP_MUL; rd = 4'd11; rs1_val = 32'd2; rs2_val = 32'd2; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_idle(n);
    run(OP_MUL, 4'd12, 32'd9, 32'd9, 32'd81);
    run(OP_DIV, 4'd13, 32'd100, 32'd7, 32'd14);

    // async reset mid-divide aborts without a write
    do_op(OP_DIV, 4'd15, 32'd1234, 32'd5, 32'd246, 1'b0);
    repeat (9) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_wb_write", 64'(wb_write), 64'(0));
    check("abort_wb_rd", 64'(wb_rd), 64'(0));
    check("abort_wb_data", 64'(wb_data), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    last_rd = '0; last_data = '0;
    run(OP_MUL, 4'd1, 32'd3, 32'd4, 32'd12);

    repeat (3) @(negedge clk);
    check("hold_rd_final", 64'(wb_rd), 64'(last_rd));
    check("hold_data_final", 64'(wb_data), 64'(last_data));
    check("pending_writes", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
